computie_bus_master_arb: RTL and testbench

- Bus-master controller for the Computie multiplexed address/data bus.
- Arbitrates between two internal requesters using round-robin, acquires the external bus, and runs one read or write cycle per grant.
- Drives the transceiver controls (send_receive, addr_oe, data_oe, data_dir) and the demux data path.
- It is the master-side counterpart of the existing bus-device control logic, so FPGA logic can initiate bus cycles.

---
 rtl/computie_bus_master_arb.sv | 148 ++++++++++++++
 tb/tb_computie_bus_master_arb.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/computie_bus_master_arb.sv
// Bus master for the Computie multiplexed address/data bus: round-robin arbitration
// between two internal requesters, then one read or write bus cycle per grant.
module computie_bus_master_arb #(
  parameter int BITWIDTH = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            req_write,
  input  logic [2*BITWIDTH-1:0] req_addr,
  input  logic [2*BITWIDTH-1:0] req_wdata,
  output logic [BITWIDTH-1:0]   rdata,
  output logic [1:0]            done,
  output logic [1:0]            error,
  output logic                  bus_request,
  input  logic                  bus_grant,
  output logic                  addr_strobe,
  output logic                  read_write,
  input  logic                  data_ack,
  output logic                  send_receive,
  output logic                  addr_oe,
  output logic                  data_oe,
  output logic                  data_dir,
  input  logic [BITWIDTH-1:0]   from_bus,
  output logic [BITWIDTH-1:0]   to_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_DATA, S_WAIT, S_DONE, S_FAIL
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  // The counter holds the number of cycles already waited; abort when this one would be the TIMEOUT-th.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                ptr;
  logic                idx;
  logic                wr;
  logic [BITWIDTH-1:0] addr;
  logic [BITWIDTH-1:0] wdata;
  logic                win;

  always_comb begin
    win = req[1];
    if (req == 2'b11) win = ptr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ptr          <= 1'b0;
      idx          <= 1'b0;
      wr           <= 1'b0;
      addr         <= '0;
      wdata        <= '0;
      rdata        <= '0;
      to_bus       <= '0;
      done         <= '0;
      error        <= '0;
      bus_request  <= 1'b1;
      addr_strobe  <= 1'b1;
      read_write   <= 1'b1;
      send_receive <= 1'b0;
      addr_oe      <= 1'b0;
      data_oe      <= 1'b0;
      data_dir     <= 1'b1;
    end else begin
      done  <= '0;
      error <= '0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            idx         <= win;
            wr          <= req_write[win];
            addr        <= win ? req_addr[2*BITWIDTH-1:BITWIDTH]  : req_addr[BITWIDTH-1:0];
            wdata       <= win ? req_wdata[2*BITWIDTH-1:BITWIDTH] : req_wdata[BITWIDTH-1:0];
            bus_request <= 1'b0;
            cnt         <= '0;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (!bus_grant) begin
            to_bus       <= addr;
            send_receive <= 1'b1;
            addr_oe      <= 1'b1;
            read_write   <= !wr;
            addr_strobe  <= 1'b0;
            state        <= S_ADDR;
          end else if (cnt >= TO_LAST) begin
            bus_request <= 1'b1;
            done[idx]   <= 1'b1;
            error[idx]  <= 1'b1;
            state       <= S_FAIL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ADDR: begin
          addr_oe  <= 1'b0;
          data_oe  <= 1'b1;
          data_dir <= read_write;
          if (wr) begin
            to_bus       <= wdata;
            send_receive <= 1'b1;
          end else begin
            send_receive <= 1'b0;
          end
          state <= S_DATA;
        end
        S_DATA: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Outputs are registered, so the release happens on the way into DONE/FAIL.
          if (!data_ack || cnt >= TO_LAST) begin
            addr_strobe  <= 1'b1;
            data_oe      <= 1'b0;
            send_receive <= 1'b0;
            bus_request  <= 1'b1;
            read_write   <= 1'b1;
            done[idx]    <= 1'b1;
            if (!data_ack) begin
              if (!wr) rdata <= from_bus;
              state <= S_DONE;
            end else begin
              error[idx] <= 1'b1;
              state      <= S_FAIL;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE, S_FAIL: begin
          ptr   <= ~idx;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_computie_bus_master_arb.sv
// Randomized bench for computie_bus_master_arb: a reactive bus agent plus a
// transaction-level model predicting winner, latency, error and read data.
module tb_computie_bus_master_arb;
  localparam int BW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      req = '0;
  logic [1:0]      req_write = '0;
  logic [2*BW-1:0] req_addr = '0;
  logic [2*BW-1:0] req_wdata = '0;
  logic [BW-1:0]   rdata;
  logic [1:0]      done;
  logic [1:0]      error;
  logic            bus_request;
  logic            bus_grant = 1'b1;
  logic            addr_strobe;
  logic            read_write;
  logic            data_ack = 1'b1;
  logic            send_receive;
  logic            addr_oe;
  logic            data_oe;
  logic            data_dir;
  logic [BW-1:0]   from_bus = '0;
  logic [BW-1:0]   to_bus;

  computie_bus_master_arb #(.BITWIDTH(BW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata), .done(done),
    .error(error), .bus_request(bus_request), .bus_grant(bus_grant),
    .addr_strobe(addr_strobe), .read_write(read_write), .data_ack(data_ack),
    .send_receive(send_receive), .addr_oe(addr_oe), .data_oe(data_oe),
    .data_dir(data_dir), .from_bus(from_bus), .to_bus(to_bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic        last_win = 1'b1;
  logic [BW-1:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {bus_request, addr_strobe, read_write, send_receive, addr_oe, data_oe, data_dir},
        7'b1110001);
    chk({tag, "_pulse"}, {done, error}, 4'b0000);
    chk({tag, "_data"}, {rdata, to_bus}, 64'h0);
  endtask

  task automatic run_txn(input logic [1:0] pat, input logic [1:0] wr,
                         input logic [BW-1:0] a0, input logic [BW-1:0] a1,
                         input logic [BW-1:0] w0, input logic [BW-1:0] w1,
                         input int g, input int a, input logic [BW-1:0] fb, input int rst_at);
    logic          win;
    logic          ewr;
    logic [BW-1:0] ea;
    logic [BW-1:0] ew;
    logic          exp_err;
    int            exp_lat;
    int            gcnt;
    int            acnt;
    bit            seen;
    win  = (pat == 2'b11) ? ~last_win : pat[1];
    ewr  = wr[win];
    ea   = win ? a1 : a0;
    ew   = win ? w1 : w0;
    gcnt = 0;
    acnt = 0;
    seen = 0;
    if (g >= TO) begin
      exp_lat = 1 + TO;  exp_err = 1'b1;
    end else if (a >= TO) begin
      exp_lat = 4 + g + TO;  exp_err = 1'b1;
    end else begin
      exp_lat = 5 + g + a;  exp_err = 1'b0;
    end
    @(negedge clk);
    req = pat; req_write = wr; req_addr = {a1, a0}; req_wdata = {w1, w0}; from_bus = fb;
    for (int t = 1; t <= 60 && !seen; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (t == 1) begin
        req_write = 2'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
      end
      if (rst_at != 0 && t == rst_at) begin
        chk("pre_rst_wait", {addr_strobe, data_oe}, 2'b01);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst_mid");
        reset = 1'b0; req = '0; bus_grant = 1'b1; data_ack = 1'b1;
        last_win = 1'b1; exp_rdata = '0;
        return;
      end
      if (addr_oe) begin
        chk("addr_bus", to_bus, ea);
        chk("addr_rw", read_write, !ewr);
      end
      if (data_oe) begin
        chk("data_dir", data_dir, !ewr);
        if (ewr) begin
          chk("wdata", to_bus, ew);
          chk("wr_send", send_receive, 1'b1);
        end else begin
          chk("rd_send", send_receive, 1'b0);
        end
      end
      if (g >= TO) chk("no_strobe", addr_strobe, 1'b1);
      if (done != 2'b00) begin
        seen = 1;
        if (!ewr && !exp_err) exp_rdata = fb;
        chk("done", done, 2'b01 << win);
        chk("error", error, exp_err ? (2'b01 << win) : 2'b00);
        chk("latency", t, exp_lat);
        chk("rdata", rdata, exp_rdata);
        chk("released", {bus_request, addr_strobe, data_oe}, 3'b110);
      end else begin
        if (bus_request == 1'b0) begin
          if (gcnt >= g) bus_grant = 1'b0;
          gcnt++;
        end else begin
          bus_grant = 1'b1;
          gcnt = 0;
        end
        if (data_oe) begin
          if (acnt >= a + 1) data_ack = 1'b0;
          acnt++;
        end else begin
          data_ack = 1'b1;
          acnt = 0;
        end
      end
    end
    if (!seen) chk("done_seen", 1'b0, 1'b1);
    req = '0; bus_grant = 1'b1; data_ack = 1'b1;
    last_win = win;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    run_txn(2'b01, 2'b00, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
    run_txn(2'b10, 2'b10, 32'h0, 32'h20, 32'h0, 32'h1234_5678, 0, 3, $urandom, 0);
    repeat (4) run_txn(2'b11, 2'($urandom), $urandom, $urandom, $urandom, $urandom, 0, 0, $urandom, 0);
    run_txn(2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 255, 0, $urandom, 0);
    run_txn(2'b01, 2'b00, 32'h44, 32'h0, 32'h0, 32'h0, 0, 255, $urandom, 0);
    run_txn(2'b01, 2'b00, 32'h48, 32'h0, 32'h0, 32'h0, 0, 255, $urandom, 6);
    run_txn(2'b01, 2'b00, 32'h4C, 32'h0, 32'h0, 32'h0, 1, 1, 32'hCAFE_F00D, 0);

    for (int i = 0; i < 40; i++) begin
      run_txn(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 9), $urandom_range(0, 9), $urandom, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
